// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file's single write port between the
// ALU result path and the load-return path (round-robin), and keeps a
// per-register pending-write scoreboard that stalls decode on outstanding writes.
module wb_port_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [4:0]        iss_dest,
  input  logic [4:0]        Rs,
  input  logic [4:0]        Rt,
  input  logic [4:0]        Rd,
  input  logic              isStore,
  input  logic [4:0]        Rp,
  output logic              stall,
  input  logic              alu_valid,
  input  logic [4:0]        alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              WR,
  output logic [4:0]        R_dest,
  output logic [DATA_W-1:0] WBData,
  output logic              sb_err
);

  // Round-robin pointer encoding: which requester won the most recent grant.
  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_LD  = 1'b1;

  // R0 and R30 are hardwired in the register file and never tracked.
  function automatic logic is_tracked(input logic [4:0] r);
    return (r != 5'd0) && (r != 5'd30);
  endfunction

  logic [1:0]        cnt [32];
  logic [4:0]        src2;
  logic              issue_fire;
  logic              commit_fire;
  logic              err_hit;
  logic              last_reg;
  logic              wr_reg;
  logic [4:0]        r_dest_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              sb_err_reg;
  logic              grant_alu;
  logic              grant_ld;

  assign src2 = isStore ? Rd : Rt;

  // Decode stall: any source with a pending write, or an issue that would
  // overflow the 2-bit pending count of its destination.
  always_comb begin
    stall = 1'b0;
    if ((cnt[Rs] != 2'd0) || (cnt[src2] != 2'd0) || (cnt[Rp] != 2'd0))
      stall = 1'b1;
    if (iss_valid && is_tracked(iss_dest) && (cnt[iss_dest] == 2'd3))
      stall = 1'b1;
  end

  assign issue_fire  = iss_valid && is_tracked(iss_dest) && !stall;
  // WR is only ever raised for tracked destinations, so every WR is a commit.
  assign commit_fire = wr_reg;
  assign err_hit     = commit_fire && (cnt[r_dest_reg] == 2'd0);

  // Per-register pending counters; untracked registers read as zero.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    if (gi == 0 || gi == 30) begin : g_untracked
      assign cnt[gi] = 2'd0;
    end else begin : g_tracked
      logic [1:0] cnt_reg;
      logic       inc;
      logic       dec;
      assign inc = issue_fire  && (iss_dest   == 5'(gi));
      assign dec = commit_fire && (r_dest_reg == 5'(gi));
      // Issue increments, commit decrements; both together cancel out.
      // Increment at 3 cannot happen because stall blocks that issue.
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= 2'd0;
        else if (inc && !dec)
          cnt_reg <= cnt_reg + 2'd1;
        else if (dec && !inc && (cnt_reg != 2'd0))
          cnt_reg <= cnt_reg - 2'd1;
      end
      assign cnt[gi] = cnt_reg;
    end
  end

  // Sticky error: a commit arrived for a register with nothing pending.
  always_ff @(posedge clk) begin
    if (rst)
      sb_err_reg <= 1'b0;
    else if (err_hit)
      sb_err_reg <= 1'b1;
  end

  // Lone requester always wins; on contention the one that did not win last.
  assign grant_alu = alu_valid && (!ld_valid  || (last_reg == LAST_LD));
  assign grant_ld  = ld_valid  && (!alu_valid || (last_reg == LAST_ALU));
  assign alu_ready = grant_alu;
  assign ld_ready  = grant_ld;

  // Output register: capture the granted write; with no grant, WR drops and
  // address/data hold. Writes to R0/R30 handshake but never assert WR.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg      <= 1'b0;
      r_dest_reg  <= 5'd0;
      wb_data_reg <= '0;
      last_reg    <= LAST_LD;
    end else if (grant_alu) begin
      wr_reg      <= is_tracked(alu_dest);
      r_dest_reg  <= alu_dest;
      wb_data_reg <= alu_data;
      last_reg    <= LAST_ALU;
    end else if (grant_ld) begin
      wr_reg      <= is_tracked(ld_dest);
      r_dest_reg  <= ld_dest;
      wb_data_reg <= ld_data;
      last_reg    <= LAST_LD;
    end else begin
      wr_reg      <= 1'b0;
    end
  end

  assign WR     = wr_reg;
  assign R_dest = r_dest_reg;
  assign WBData = wb_data_reg;
  assign sb_err = sb_err_reg;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: table-driven arbitration vectors plus
// hand-written scoreboard/stall sequences; expected write-back results go
// through a queue and are compared when the output register presents them.
module tb_wb_port_arbiter;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [4:0]        iss_dest;
  logic [4:0]        Rs, Rt, Rd, Rp;
  logic              isStore;
  logic              stall;
  logic              alu_valid;
  logic [4:0]        alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [4:0]        ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              WR;
  logic [4:0]        R_dest;
  logic [DATA_W-1:0] WBData;
  logic              sb_err;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_dest(iss_dest),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .isStore(isStore), .Rp(Rp),
    .stall(stall),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data), .ld_ready(ld_ready),
    .WR(WR), .R_dest(R_dest), .WBData(WBData), .sb_err(sb_err)
  );

  typedef struct {
    logic              av;
    logic [4:0]        ad;
    logic [DATA_W-1:0] adata;
    logic              lv;
    logic [4:0]        ldd;
    logic [DATA_W-1:0] ldata;
    logic              ea;
    logic              el;
  } vec_t;

  typedef struct {
    logic              wr;
    logic [4:0]        dest;
    logic [DATA_W-1:0] data;
  } wb_exp_t;

  vec_t              vecs [12];
  wb_exp_t           exp_q [$];
  logic [4:0]        model_dest;
  logic [DATA_W-1:0] model_data;
  int                checks = 0;
  int                errors = 0;

  function automatic vec_t mk(input logic av, input logic [4:0] ad, input logic [DATA_W-1:0] adata,
                              input logic lv, input logic [4:0] ldd, input logic [DATA_W-1:0] ldata,
                              input logic ea, input logic el);
    vec_t v;
    v.av = av; v.ad = ad; v.adata = adata;
    v.lv = lv; v.ldd = ldd; v.ldata = ldata;
    v.ea = ea; v.el = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_dest = 5'd0;
    Rs = 5'd0; Rt = 5'd0; Rd = 5'd0; Rp = 5'd0; isStore = 1'b0;
    alu_valid = 1'b0; alu_dest = 5'd0; alu_data = '0;
    ld_valid = 1'b0; ld_dest = 5'd0; ld_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_dest = 5'd0;
    model_data = '0;
    exp_q.delete();
  endtask

  // One clock cycle with inputs already driven: check combinational outputs
  // mid-cycle, queue the expected write-back, then compare after the edge.
  task automatic cycle(input logic ea, input logic el, input logic es, input string tag);
    wb_exp_t e;
    wb_exp_t got;
    #4;
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ea));
    chk({tag, ".ld_ready"},  32'(ld_ready),  32'(el));
    chk({tag, ".stall"},     32'(stall),     32'(es));
    if (ea) begin
      model_dest = alu_dest; model_data = alu_data;
      e.wr = (alu_dest != 5'd0) && (alu_dest != 5'd30);
    end else if (el) begin
      model_dest = ld_dest; model_data = ld_data;
      e.wr = (ld_dest != 5'd0) && (ld_dest != 5'd30);
    end else begin
      e.wr = 1'b0;
    end
    e.dest = model_dest;
    e.data = model_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk({tag, ".WR"},     32'(WR),     32'(got.wr));
    chk({tag, ".R_dest"}, 32'(R_dest), 32'(got.dest));
    chk({tag, ".WBData"}, WBData,      got.data);
    $display("%0t %s: alu_rdy=%0b ld_rdy=%0b stall=%0b WR=%0b R_dest=%0d WBData=0x%08h sb_err=%0b",
             $time, tag, ea, el, es, WR, R_dest, WBData, sb_err);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 5'd3,  32'hA000_0000, 1'b1, 5'd4,  32'hB000_0000, 1'b1, 1'b0);
    vecs[1]  = mk(1'b1, 5'd3,  32'hA000_0001, 1'b1, 5'd4,  32'hB000_0001, 1'b0, 1'b1);
    vecs[2]  = mk(1'b1, 5'd6,  32'hA000_0002, 1'b1, 5'd7,  32'hB000_0002, 1'b1, 1'b0);
    vecs[3]  = mk(1'b1, 5'd6,  32'hA000_0003, 1'b1, 5'd7,  32'hB000_0003, 1'b0, 1'b1);
    vecs[4]  = mk(1'b0, 5'd1,  32'hA000_0004, 1'b0, 5'd2,  32'hB000_0004, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 5'd8,  32'hA000_0005, 1'b1, 5'd9,  32'hB000_0005, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 5'd1,  32'hA000_0006, 1'b1, 5'd0,  32'hB000_0006, 1'b0, 1'b1);
    vecs[7]  = mk(1'b1, 5'd30, 32'hA000_0007, 1'b0, 5'd2,  32'hB000_0007, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 5'd10, 32'hA000_0008, 1'b1, 5'd11, 32'hB000_0008, 1'b0, 1'b1);
    vecs[9]  = mk(1'b0, 5'd10, 32'hA000_0009, 1'b0, 5'd11, 32'hB000_0009, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 5'd31, 32'hA000_000A, 1'b0, 5'd11, 32'hB000_000A, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 5'd31, 32'hA000_000B, 1'b1, 5'd1,  32'hB000_000B, 1'b0, 1'b1);

    idle();
    do_reset();
    chk("reset.WR",     32'(WR),     32'd0);
    chk("reset.R_dest", 32'(R_dest), 32'd0);
    chk("reset.WBData", WBData,      32'd0);
    chk("reset.sb_err", 32'(sb_err), 32'd0);

    // ALU-only write with nothing issued: accepted, then flagged as an error.
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle(1'b1, 1'b0, 1'b0, "A.alu_only");
    chk("A.sb_err_before_commit", 32'(sb_err), 32'd0);
    alu_valid = 1'b0; Rs = 5'd5;
    cycle(1'b0, 1'b0, 1'b0, "A.commit");
    chk("A.sb_err_after_commit", 32'(sb_err), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, "A.cnt5_zero");

    // Arbitration vectors from a clean reset (first contention grants ALU).
    idle();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      alu_valid = vecs[i].av; alu_dest = vecs[i].ad;  alu_data = vecs[i].adata;
      ld_valid  = vecs[i].lv; ld_dest  = vecs[i].ldd; ld_data  = vecs[i].ldata;
      cycle(vecs[i].ea, vecs[i].el, 1'b0, $sformatf("vec%0d", i));
    end

    // Issue r7, dependent reads stall; load write-back releases them.
    idle();
    do_reset();
    iss_valid = 1'b1; iss_dest = 5'd7;
    cycle(1'b0, 1'b0, 1'b0, "B.issue7");
    iss_valid = 1'b0; Rs = 5'd7;
    cycle(1'b0, 1'b0, 1'b1, "B.rs7");
    Rs = 5'd0; Rd = 5'd7; isStore = 1'b1;
    cycle(1'b0, 1'b0, 1'b1, "B.store_rd7");
    isStore = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "B.alu_rt0");
    Rp = 5'd7;
    cycle(1'b0, 1'b0, 1'b1, "B.rp7");
    Rp = 5'd0; Rs = 5'd7;
    ld_valid = 1'b1; ld_dest = 5'd7; ld_data = 32'h0000_0777;
    cycle(1'b0, 1'b1, 1'b1, "B.ld7_grant");
    ld_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "B.ld7_wr");
    cycle(1'b0, 1'b0, 1'b0, "B.ld7_released");
    chk("B.sb_err", 32'(sb_err), 32'd0);

    // Saturate r9 at three pending, block a fourth, then free one slot.
    idle();
    iss_valid = 1'b1; iss_dest = 5'd9;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0, $sformatf("C.issue9_%0d", k));
    alu_valid = 1'b1; alu_dest = 5'd9; alu_data = 32'h0000_0999;
    cycle(1'b1, 1'b0, 1'b1, "C.full_commit_grant");
    alu_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "C.full_commit_wr");
    cycle(1'b0, 1'b0, 1'b0, "C.issue_accepted");
    cycle(1'b0, 1'b0, 1'b1, "C.full_again");
    iss_valid = 1'b0; Rs = 5'd9;
    ld_valid = 1'b1; ld_dest = 5'd9; ld_data = 32'h0000_0099;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1, $sformatf("C.drain_%0d", k));
    ld_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "C.last_wr");
    cycle(1'b0, 1'b0, 1'b0, "C.empty");
    chk("C.sb_err", 32'(sb_err), 32'd0);

    // Untracked registers: writes handshake without WR, issues never stall.
    idle();
    do_reset();
    ld_valid = 1'b1; ld_dest = 5'd30; ld_data = 32'h3030_3030;
    cycle(1'b0, 1'b1, 1'b0, "D.ld30");
    ld_dest = 5'd0; ld_data = 32'h0000_0F0F;
    cycle(1'b0, 1'b1, 1'b0, "D.ld0");
    ld_valid = 1'b0;
    Rs = 5'd30; Rt = 5'd0; Rp = 5'd30;
    for (int k = 0; k < 5; k++) begin
      iss_valid = 1'b1;
      iss_dest = (k % 2 == 1) ? 5'd30 : 5'd0;
      cycle(1'b0, 1'b0, 1'b0, $sformatf("D.issue_untracked_%0d", k));
    end
    chk("D.sb_err", 32'(sb_err), 32'd0);

    // Simultaneous issue and commit on r12 leave its count unchanged.
    idle();
    iss_valid = 1'b1; iss_dest = 5'd12;
    cycle(1'b0, 1'b0, 1'b0, "E.issue12");
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_dest = 5'd12; alu_data = 32'h1212_1212;
    cycle(1'b1, 1'b0, 1'b0, "E.grant12");
    alu_valid = 1'b0; iss_valid = 1'b1; iss_dest = 5'd12;
    cycle(1'b0, 1'b0, 1'b0, "E.issue_and_commit12");
    iss_valid = 1'b0; Rs = 5'd12;
    cycle(1'b0, 1'b0, 1'b1, "E.still_pending");
    alu_valid = 1'b1; alu_data = 32'h1212_0000;
    cycle(1'b1, 1'b0, 1'b1, "E.grant12_b");
    alu_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b1, "E.commit12_b");
    cycle(1'b0, 1'b0, 1'b0, "E.released");
    chk("E.sb_err", 32'(sb_err), 32'd0);

    // Reset mid-stream discards pending counts, captured write and sb_err.
    idle();
    alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 32'h2020_2020;
    cycle(1'b1, 1'b0, 1'b0, "F.stray20");
    alu_valid = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, "F.stray20_commit");
    chk("F.sb_err_set", 32'(sb_err), 32'd1);
    iss_valid = 1'b1; iss_dest = 5'd13;
    cycle(1'b0, 1'b0, 1'b0, "F.issue13");
    iss_valid = 1'b0; Rs = 5'd13;
    alu_valid = 1'b1; alu_dest = 5'd14; alu_data = 32'h1414_1414;
    rst = 1'b1;
    #4;
    chk("F.pre_rst.stall",     32'(stall),     32'd1);
    chk("F.pre_rst.alu_ready", 32'(alu_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    alu_valid = 1'b0;
    model_dest = 5'd0;
    model_data = '0;
    exp_q.delete();
    chk("F.rst.WR",     32'(WR),     32'd0);
    chk("F.rst.R_dest", 32'(R_dest), 32'd0);
    chk("F.rst.WBData", WBData,      32'd0);
    chk("F.rst.sb_err", 32'(sb_err), 32'd0);
    $display("%0t F.rst: WR=%0b R_dest=%0d WBData=0x%08h sb_err=%0b", $time, WR, R_dest, WBData, sb_err);
    cycle(1'b0, 1'b0, 1'b0, "F.after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
